// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator: publishes pixel coordinates upstream,
// takes the matching colour one cycle later and drives blanked RGB with aligned syncs.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        CLK25MHZ,
  input  logic        ck_rst,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  input  logic [11:0] pixel_rgb,
  output logic        next_line,
  output logic        frame_start,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  // Bounds are 11 bits wide so a sync region ending exactly at 1024 still compares correctly.
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        valid_q, valid_d, valid_dly_q, valid_dly_d;
  logic        hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
  logic        hs_lvl_q, hs_lvl_d, vs_lvl_q, vs_lvl_d;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = 10'd0;
      if (v_q == V_LAST) begin
        v_d = 10'd0;
      end else begin
        v_d = v_q + 10'd1;
      end
    end
    // pixel_valid is registered alongside the counters, so it is judged on their next value.
    valid_d     = ({1'b0, h_d} < H_ACT) && ({1'b0, v_d} < V_ACT);
    valid_dly_d = valid_q;
    hs_raw_d    = ({1'b0, h_q} >= HS_START) && ({1'b0, h_q} < HS_END);
    vs_raw_d    = ({1'b0, v_q} >= VS_START) && ({1'b0, v_q} < VS_END);
    hs_lvl_d    = hs_raw_q ? HS_POL : ~HS_POL;
    vs_lvl_d    = vs_raw_q ? VS_POL : ~VS_POL;
    rgb_d       = valid_dly_q ? pixel_rgb : 12'h000;
  end

  always_ff @(posedge CLK25MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      h_q         <= 10'd0;
      v_q         <= 10'd0;
      valid_q     <= 1'b0;
      valid_dly_q <= 1'b0;
      hs_raw_q    <= 1'b0;
      vs_raw_q    <= 1'b0;
      hs_lvl_q    <= ~HS_POL;
      vs_lvl_q    <= ~VS_POL;
      rgb_q       <= 12'h000;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      valid_q     <= valid_d;
      valid_dly_q <= valid_dly_d;
      hs_raw_q    <= hs_raw_d;
      vs_raw_q    <= vs_raw_d;
      hs_lvl_q    <= hs_lvl_d;
      vs_lvl_q    <= vs_lvl_d;
      rgb_q       <= rgb_d;
    end
  end

  // The last blanking line also requests, so the source can prefetch line 0 of the next frame.
  assign next_line   = ({1'b0, h_q} == H_ACT) &&
                       ((({1'b0, v_q} + 11'd1) < V_ACT) || (v_q == V_LAST));
  assign frame_start = (h_q == 10'd0) && (v_q == 10'd0);

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign pixel_valid = valid_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_lvl_q;
  assign vga_vs      = vs_lvl_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a shrunken, inverted-polarity
// instance, both compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct {
    int   ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    logic hpol, vpol;
  } cfg_t;

  typedef struct {
    int          x, y;
    logic        valid, nl, fs, hs, vs;
    logic [11:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [11:0] rgb_a, rgb_b;
  logic [9:0]  px_a, py_a, px_b, py_b;
  logic        pv_a, nl_a, fs_a, hs_a, vs_a;
  logic        pv_b, nl_b, fs_b, hs_b, vs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  vga_timing_gen dut_a (
    .CLK25MHZ(clk), .ck_rst(rst_a), .pixel_x(px_a), .pixel_y(py_a), .pixel_valid(pv_a),
    .pixel_rgb(rgb_a), .next_line(nl_a), .frame_start(fs_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .CLK25MHZ(clk), .ck_rst(rst_b), .pixel_x(px_b), .pixel_y(py_b), .pixel_valid(pv_b),
    .pixel_rgb(rgb_b), .next_line(nl_b), .frame_start(fs_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b)
  );

  cfg_t ca, cb;
  int   checks = 0;
  int   errors = 0;
  int   ta, tb;
  int   cyc = 0;
  logic seg0 = 1'b1;
  logic [11:0] samp_a, samp_b;

  // Edges counted since reset release: the model's notion of time.
  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) ta <= 0;
    else        ta <= ta + 1;
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) tb <= 0;
    else        tb <= tb + 1;
  end

  // Colour that was on the pin during the previous cycle.
  always @(posedge clk) begin
    samp_a <= rgb_a;
    samp_b <= rgb_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic active(input cfg_t c, input int t);
    int ht, vt;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    return (t > 0) && ((t % ht) < c.ha) && (((t / ht) % vt) < c.va);
  endfunction

  function automatic exp_t model(input cfg_t c, input int t, input logic [11:0] rgb_prev);
    exp_t e;
    int ht, vt, h, v, h2, v2;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    h = t % ht;
    v = (t / ht) % vt;
    e.x     = h;
    e.y     = v;
    e.valid = active(c, t);
    e.nl    = (h == c.ha) && ((v + 1 < c.va) || (v == vt - 1));
    e.fs    = (h == 0) && (v == 0);
    e.hs    = ~c.hpol;
    e.vs    = ~c.vpol;
    e.rgb   = 12'h000;
    if (t >= 2) begin
      h2 = (t - 2) % ht;
      v2 = ((t - 2) / ht) % vt;
      if (h2 >= c.ha + c.hfp && h2 < c.ha + c.hfp + c.hsw) e.hs = c.hpol;
      if (v2 >= c.va + c.vfp && v2 < c.va + c.vfp + c.vsw) e.vs = c.vpol;
      if (active(c, t - 2)) e.rgb = rgb_prev;
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input cfg_t c, input int t, input logic [11:0] rp,
                     input logic [9:0] x, input logic [9:0] y, input logic v, input logic nl,
                     input logic fs, input logic [11:0] rgb, input logic hs, input logic vs);
    exp_t e;
    e = model(c, t, rp);
    chk({tag, ".pixel_x"}, 32'(x), e.x);
    chk({tag, ".pixel_y"}, 32'(y), e.y);
    chk({tag, ".pixel_valid"}, 32'(v), 32'(e.valid));
    chk({tag, ".next_line"}, 32'(nl), 32'(e.nl));
    chk({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({tag, ".rgb"}, 32'(rgb), 32'(e.rgb));
    chk({tag, ".hs"}, 32'(hs), 32'(e.hs));
    chk({tag, ".vs"}, 32'(vs), 32'(e.vs));
  endtask

  int   hs_first = -1, hs_second = -1, hs_len = 0;
  logic hs_prev = 1'b1;
  int   fsb1 = -1, fsb2 = -1, nlb = 0;
  int   vsb_first = -1, vsb_len = 0, hsb_first = -1, hsb_len = 0;
  logic vsb_done = 1'b0, hsb_done = 1'b0;
  int   blank_viol = 0;

  task automatic step();
    exp_t pa, pb;
    cmp("A", ca, ta, samp_a, px_a, py_a, pv_a, nl_a, fs_a, {r_a, g_a, b_a}, hs_a, vs_a);
    cmp("B", cb, tb, samp_b, px_b, py_b, pv_b, nl_b, fs_b, {r_b, g_b, b_b}, hs_b, vs_b);

    if ({r_a, g_a, b_a} != 12'h000 && (hs_a == 1'b0 || vs_a == 1'b0)) blank_viol++;
    if ({r_b, g_b, b_b} != 12'h000 && (hs_b == 1'b1 || vs_b == 1'b1)) blank_viol++;

    if (seg0) begin
      if (ta == 2)    chk("pin_rgb_t2", 32'({r_a, g_a, b_a}), 32'h000);
      if (ta == 3)    chk("pin_rgb_t3", 32'({r_a, g_a, b_a}), 32'hFFF);
      if (ta == 5)    chk("pin_x_t5", 32'(px_a), 32'd5);
      if (ta == 641)  chk("pin_rgb_h639", 32'({r_a, g_a, b_a}), 32'hFFF);
      if (ta == 642)  chk("pin_rgb_h640", 32'({r_a, g_a, b_a}), 32'h000);
      if (ta == 657)  chk("pin_hs_idle", 32'(hs_a), 32'd1);
      if (ta == 800)  chk("pin_xy_line1", 32'({px_a, py_a}), 32'({10'd0, 10'd1}));
      if (ta == 1805) chk("pin_rgb_coord", 32'({r_a, g_a, b_a}), 32'hB2A);

      if (hs_a === 1'b0 && hs_prev === 1'b1) begin
        if (hs_first < 0) hs_first = ta;
        else if (hs_second < 0) hs_second = ta;
      end
      if (hs_a === 1'b0 && hs_first >= 0 && hs_second < 0) hs_len++;
      hs_prev = hs_a;

      if (fs_b === 1'b1 && tb > 0) begin
        if (fsb1 < 0) fsb1 = tb;
        else if (fsb2 < 0) fsb2 = tb;
      end
      if (nl_b === 1'b1 && fsb1 >= 0 && fsb2 < 0) nlb++;
      if (vs_b === 1'b1 && !vsb_done) begin
        if (vsb_first < 0) vsb_first = tb;
        vsb_len++;
      end else if (vsb_first >= 0) begin
        vsb_done = 1'b1;
      end
      if (hs_b === 1'b1 && !hsb_done) begin
        if (hsb_first < 0) hsb_first = tb;
        hsb_len++;
      end else if (hsb_first >= 0) begin
        hsb_done = 1'b1;
      end
    end else begin
      if (ta == 658) chk("pin_hs_after_rst", 32'(hs_a), 32'd0);
    end

    // Stimulus for the cycle now starting: all-white, coordinate pattern, then random.
    if (cyc < 1700) begin
      rgb_a = 12'hFFF;
      rgb_b = 12'hFFF;
    end else if (cyc < 2600) begin
      pa = model(ca, (ta > 0) ? ta - 1 : 0, 12'h000);
      pb = model(cb, (tb > 0) ? tb - 1 : 0, 12'h000);
      rgb_a = {4'(pa.x), 4'(pa.y), 4'hA};
      rgb_b = {4'(pb.x), 4'(pb.y), 4'hA};
    end else begin
      rgb_a = 12'($urandom);
      rgb_b = 12'($urandom);
    end
  endtask

  initial begin
    ca = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cb = '{16, 2, 4, 3, 6, 1, 2, 2, 1'b1, 1'b1};
    rst_a = 1'b0;
    rst_b = 1'b0;
    rgb_a = 12'h000;
    rgb_b = 12'h000;

    repeat (3) begin
      @(negedge clk);
      step();
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    chk("fs_at_release", 32'(fs_a), 32'd1);

    for (int i = 0; i < 1900; i++) begin
      @(negedge clk);
      step();
      cyc++;
    end

    // A now sits at h=300, v=2; reset lands between clock edges.
    chk("pre_rst_x", 32'(px_a), 32'd300);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    seg0  = 1'b0;
    #1;
    chk("async_rst_x", 32'(px_a), 32'd0);
    chk("async_rst_y", 32'(py_a), 32'd0);
    chk("async_rst_valid", 32'(pv_a), 32'd0);
    chk("async_rst_rgb", 32'({r_a, g_a, b_a}), 32'h000);
    chk("async_rst_sync", 32'({hs_a, vs_a}), 32'b11);
    chk("async_rst_sync_b", 32'({hs_b, vs_b}), 32'b00);
    chk("async_rst_nl", 32'(nl_a), 32'd0);

    repeat (2) begin
      @(negedge clk);
      step();
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      step();
      cyc++;
    end

    chk("hs_first_edge", hs_first, 658);
    chk("hs_width", hs_len, 96);
    chk("hs_period", hs_second - hs_first, 800);
    chk("b_hs_first", hsb_first, 20);
    chk("b_hs_width", hsb_len, 4);
    chk("b_vs_first", vsb_first, 177);
    chk("b_vs_width", vsb_len, 50);
    chk("b_frame_period", fsb2 - fsb1, 275);
    chk("b_next_line_count", nlb, 6);
    chk("blank_during_sync", blank_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
